// File: rtl/mem_bus_ctrl.sv
// Memory/I-O bus controller: 256x16 RAM, registered reads, sticky bus error, access counter.
// Define MEM_BUS_IO_EN to build the LED/switch registers and the switch synchronizer.
module mem_bus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [7:0]  SW,
  output logic [15:0] read_data,
  output logic        rd_valid,
  output logic [7:0]  LEDR,
  output logic        bus_err,
  output logic [15:0] access_cnt
);

  localparam int         RAM_WORDS = 256;
  localparam logic [8:0] LED_ADDR  = 9'h100;
  localparam logic [8:0] SW_ADDR   = 9'h140;

  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  typedef enum logic {
    S_IDLE,
    S_RDATA
  } state_t;

  state_t state, state_next;

  logic [15:0] mem [RAM_WORDS];

  logic        cmd_read, cmd_write, cmd_illegal;
  logic        ram_sel, led_sel, sw_sel;
  logic        access_err;
  logic [15:0] rd_mux;
  logic [7:0]  sw_sync;

  // Command and address decode
  always_comb begin
    cmd_read    = (mem_cmd == MREAD);
    cmd_write   = (mem_cmd == MWRITE);
    cmd_illegal = !(cmd_read || cmd_write || (mem_cmd == MNONE));
    ram_sel     = !mem_addr[8];
`ifdef MEM_BUS_IO_EN
    led_sel     = (mem_addr == LED_ADDR);
    sw_sel      = (mem_addr == SW_ADDR);
`else
    led_sel     = 1'b0;
    sw_sel      = 1'b0;
`endif
    // LED is write-only and SW is read-only; the opposite direction is an error.
    access_err  = (cmd_read  && !(ram_sel || sw_sel)) ||
                  (cmd_write && !(ram_sel || led_sel));
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_mux = 16'h0000;
    if (ram_sel)
      rd_mux = mem[mem_addr[7:0]];
    else if (sw_sel)
      rd_mux = {8'h00, sw_sync};
  end

  // NOTE: RAM contents carry no reset so the array maps onto a plain block RAM; reset only gates the write.
  always_ff @(posedge clk) begin
    if (!reset && cmd_write && ram_sel)
      mem[mem_addr[7:0]] <= write_data;
  end

`ifdef MEM_BUS_IO_EN
  logic [7:0] sw_meta;
  logic [7:0] led_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
      led_q   <= 8'h00;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (cmd_write && led_sel)
        led_q <= write_data[7:0];
    end
  end

  assign LEDR = led_q;
`else
  logic unused_sw;

  assign unused_sw = ^SW;
  assign sw_sync   = 8'h00;
  assign LEDR      = 8'h00;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      read_data  <= 16'h0000;
      bus_err    <= 1'b0;
      access_cnt <= 16'h0000;
    end else begin
      state <= state_next;
      if (cmd_read)
        read_data <= rd_mux;
      if (cmd_illegal || access_err)
        bus_err <= 1'b1;
      if (cmd_read || cmd_write)
        access_cnt <= access_cnt + 16'd1;
    end
  end

  // An illegal command carries no read, so it also lands in S_IDLE.
  always_comb begin
    state_next = S_IDLE;
    rd_valid   = 1'b0;
    if (cmd_read)
      state_next = S_RDATA;
    if (state == S_RDATA)
      rd_valid = 1'b1;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; expected values are hand-computed constants.
module tb_mem_bus_ctrl;

  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  SW;
  logic [15:0] read_data;
  logic        rd_valid;
  logic [7:0]  LEDR;
  logic        bus_err;
  logic [15:0] access_cnt;

  int passed = 0;
  int total  = 0;

  mem_bus_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .SW         (SW),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .LEDR       (LEDR),
    .bus_err    (bus_err),
    .access_cnt (access_cnt)
  );

  always #5 clk = ~clk;

  // Drive on the falling edge, let one rising edge sample, then settle before checks.
  task automatic step(input logic [2:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    @(negedge clk);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset      = 1'b1;
    mem_cmd    = MNONE;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
    SW         = 8'h00;

    // Reset
    step(MNONE, 9'h000, 16'h0000);
    reset = 1'b0;
    check("rst_read_data", read_data, 16'h0000);
    check("rst_rd_valid", {15'd0, rd_valid}, 16'h0000);
    check("rst_ledr", {8'd0, LEDR}, 16'h0000);
    check("rst_bus_err", {15'd0, bus_err}, 16'h0000);
    check("rst_access_cnt", access_cnt, 16'h0000);

    // Adjacent write then read
    step(MWRITE, 9'h005, 16'hBEEF);
    check("wr_no_valid", {15'd0, rd_valid}, 16'h0000);
    step(MREAD, 9'h005, 16'h0000);
    check("raw_data", read_data, 16'hBEEF);
    check("raw_valid", {15'd0, rd_valid}, 16'h0001);
    check("raw_cnt", access_cnt, 16'h0002);
    step(MNONE, 9'h000, 16'h0000);
    check("idle_valid", {15'd0, rd_valid}, 16'h0000);
    check("idle_hold", read_data, 16'hBEEF);

    // Two-cycle fetch
    step(MWRITE, 9'h000, 16'hD105);
    step(MREAD, 9'h000, 16'h0000);
    check("fetch1_valid", {15'd0, rd_valid}, 16'h0001);
    step(MREAD, 9'h000, 16'h0000);
    check("fetch2_data", read_data, 16'hD105);
    check("fetch2_valid", {15'd0, rd_valid}, 16'h0001);
    step(MNONE, 9'h000, 16'h0000);
    check("fetch_done_valid", {15'd0, rd_valid}, 16'h0000);
    check("fetch_cnt", access_cnt, 16'h0005);

    // Top RAM word
    step(MWRITE, 9'h0FF, 16'h1234);
    step(MREAD, 9'h0FF, 16'h0000);
    check("ram_top", read_data, 16'h1234);
    check("ram_top_no_err", {15'd0, bus_err}, 16'h0000);

    // I/O registers
    step(MWRITE, 9'h100, 16'h12A5);
`ifdef MEM_BUS_IO_EN
    check("led_write", {8'd0, LEDR}, 16'h00A5);
    check("led_no_err", {15'd0, bus_err}, 16'h0000);
`else
    check("led_absent", {8'd0, LEDR}, 16'h0000);
    check("led_absent_err", {15'd0, bus_err}, 16'h0001);
`endif
    SW = 8'h3C;
    step(MNONE, 9'h000, 16'h0000);
    step(MNONE, 9'h000, 16'h0000);
    step(MREAD, 9'h140, 16'h0000);
`ifdef MEM_BUS_IO_EN
    check("sw_read", read_data, 16'h003C);
    check("sw_no_err", {15'd0, bus_err}, 16'h0000);
`else
    check("sw_absent", read_data, 16'h0000);
`endif
    check("io_cnt", access_cnt, 16'h0009);

    // Illegal command: no access, no count, FSM idle
    step(3'b011, 9'h005, 16'h0000);
    check("illegal_err", {15'd0, bus_err}, 16'h0001);
    check("illegal_cnt", access_cnt, 16'h0009);
    check("illegal_valid", {15'd0, rd_valid}, 16'h0000);
    step(MREAD, 9'h005, 16'h0000);
    check("illegal_ram_kept", read_data, 16'hBEEF);
    step(MREAD, 9'h1FF, 16'h0000);
    check("unmapped_data", read_data, 16'h0000);
    check("unmapped_cnt", access_cnt, 16'h000B);
    step(MNONE, 9'h000, 16'h0000);
    step(MNONE, 9'h000, 16'h0000);
    check("err_sticky", {15'd0, bus_err}, 16'h0001);

    // Reset clears error and count, then wrap the counter
    reset = 1'b1;
    step(MNONE, 9'h000, 16'h0000);
    reset = 1'b0;
    check("rst2_err", {15'd0, bus_err}, 16'h0000);
    check("rst2_cnt", access_cnt, 16'h0000);
    for (int i = 0; i < 65535; i++)
      step(MREAD, 9'h000, 16'h0000);
    check("cnt_max", access_cnt, 16'hFFFF);
    step(MREAD, 9'h000, 16'h0000);
    check("cnt_wrap", access_cnt, 16'h0000);

    // Reset overrides a concurrent write
    step(MWRITE, 9'h010, 16'h2222);
    step(MREAD, 9'h010, 16'h0000);
    check("pre_rst_data", read_data, 16'h2222);
    reset = 1'b1;
    step(MWRITE, 9'h010, 16'h1111);
    reset = 1'b0;
    check("rst_ovr_valid", {15'd0, rd_valid}, 16'h0000);
    check("rst_ovr_data", read_data, 16'h0000);
    check("rst_ovr_cnt", access_cnt, 16'h0000);
    step(MREAD, 9'h010, 16'h0000);
    check("rst_ovr_ram", read_data, 16'h2222);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
